// File: rtl/mc_scoreboard.sv
// mc_scoreboard: per-unit scoreboard and round-robin writeback arbiter for multi-cycle execute units
module mc_scoreboard #(
   parameter int NUNITS = 4,
   parameter int XLEN = 32,
   parameter int NFLAGS = 5,
   localparam int UW = NUNITS > 1 ? $clog2(NUNITS) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     issue_valid,
   input  logic [UW-1:0]            issue_unit,
   input  logic [5:0]               issue_rd,
   input  logic [17:0]              issue_rs,
   input  logic [2:0]               issue_rs_used,
   output logic                     issue_ready,
   output logic [NUNITS-1:0]        unit_start,
   input  logic [NUNITS-1:0]        unit_done,
   input  logic [NUNITS*XLEN-1:0]   unit_result,
   input  logic [NUNITS*NFLAGS-1:0] unit_flags,
   output logic                     wb_valid,
   input  logic                     wb_ready,
   output logic [5:0]               wb_rd,
   output logic [XLEN-1:0]          wb_data,
   output logic [NFLAGS-1:0]        wb_flags,
   output logic [NUNITS-1:0]        busy_units,
   output logic                     err_spurious
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} ustate_t;
   ustate_t state [NUNITS];
   ustate_t state_nxt [NUNITS];
   logic [63:0] pending, pending_nxt;
   logic [5:0] buf_rd [NUNITS];
   logic [XLEN-1:0] buf_data [NUNITS];
   logic [NFLAGS-1:0] buf_flags [NUNITS];
   logic [UW-1:0] rr_ptr, lock_unit, sel, cand;
   logic [NUNITS-1:0] done_vec, run_vec;
   logic locked, found, src_hazard, accept, grant;
   always_comb begin
      for (int u = 0; u < NUNITS; u++) begin
         done_vec[u] = state[u] == DONE;
         run_vec[u] = state[u] == RUN;
         busy_units[u] = state[u] != IDLE;
      end
   end
   // x0 is never pending, so it can never raise a hazard
   always_comb begin
      src_hazard = 1'b0;
      for (int i = 0; i < 3; i++)
         if (issue_rs_used[i] && pending[issue_rs[6*i +: 6]]) src_hazard = 1'b1;
      issue_ready = !src_hazard && !pending[issue_rd] && !busy_units[issue_unit];
      accept = issue_valid && issue_ready;
      unit_start = accept ? NUNITS'(1) << issue_unit : '0;
   end
   // A stalled offer stays locked to its unit so later completions cannot preempt it
   always_comb begin
      sel = lock_unit;
      found = locked;
      cand = rr_ptr;
      for (int k = 0; k < NUNITS; k++) begin
         cand = UW'((int'(rr_ptr) + k) % NUNITS);
         if (!found && done_vec[cand]) begin
            sel = cand;
            found = 1'b1;
         end
      end
      wb_valid = |done_vec;
      wb_rd = buf_rd[sel];
      wb_data = buf_data[sel];
      wb_flags = buf_flags[sel];
      grant = wb_valid && wb_ready;
   end
   always_comb begin
      for (int u = 0; u < NUNITS; u++) begin
         state_nxt[u] = state[u];
         if (state[u] == IDLE && accept && issue_unit == UW'(u)) state_nxt[u] = RUN;
         if (state[u] == RUN && unit_done[u]) state_nxt[u] = DONE;
         if (state[u] == DONE && grant && sel == UW'(u)) state_nxt[u] = IDLE;
      end
   end
   always_comb begin
      pending_nxt = pending;
      if (grant) pending_nxt[wb_rd] = 1'b0;
      if (accept && issue_rd != 6'd0) pending_nxt[issue_rd] = 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int u = 0; u < NUNITS; u++) state[u] <= IDLE;
         pending <= '0;
         rr_ptr <= '0;
         locked <= 1'b0;
         lock_unit <= '0;
         err_spurious <= 1'b0;
      end else begin
         for (int u = 0; u < NUNITS; u++) state[u] <= state_nxt[u];
         pending <= pending_nxt;
         if (grant) rr_ptr <= UW'((int'(sel) + 1) % NUNITS);
         locked <= wb_valid && !wb_ready;
         lock_unit <= sel;
         if (|(unit_done & ~run_vec)) err_spurious <= 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      for (int u = 0; u < NUNITS; u++) begin
         if (accept && issue_unit == UW'(u)) buf_rd[u] <= issue_rd;
         if (state[u] == RUN && unit_done[u]) begin
            buf_data[u] <= unit_result[u*XLEN +: XLEN];
            buf_flags[u] <= unit_flags[u*NFLAGS +: NFLAGS];
         end
      end
   end
endmodule

// File: tb/tb_mc_scoreboard.sv
// tb_mc_scoreboard: directed and randomized checks of mc_scoreboard against a transaction-level model
module tb_mc_scoreboard;
   localparam int N = 4, XL = 32, NF = 5;
   logic clk = 1'b0;
   logic rst, issue_valid, issue_ready, wb_valid, wb_ready, err_spurious;
   logic [1:0] issue_unit;
   logic [5:0] issue_rd, wb_rd;
   logic [17:0] issue_rs;
   logic [2:0] issue_rs_used;
   logic [N-1:0] unit_start, unit_done, busy_units;
   logic [N*XL-1:0] unit_result;
   logic [N*NF-1:0] unit_flags;
   logic [XL-1:0] wb_data;
   logic [NF-1:0] wb_flags;
   int checks = 0, failures = 0;
   // model: 0 idle, 1 running, 2 result waiting for writeback
   int m_st [N];
   logic [5:0] m_rd [N];
   logic [XL-1:0] m_data [N];
   logic [NF-1:0] m_flags [N];
   int m_rr, m_lock, exp_sel;
   bit m_err, exp_ready, exp_wbv;
   logic [N-1:0] exp_start, exp_busy;
   always #5 clk = ~clk;
   mc_scoreboard #(.NUNITS(N), .XLEN(XL), .NFLAGS(NF)) dut (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_unit(issue_unit),
      .issue_rd(issue_rd), .issue_rs(issue_rs), .issue_rs_used(issue_rs_used),
      .issue_ready(issue_ready), .unit_start(unit_start), .unit_done(unit_done),
      .unit_result(unit_result), .unit_flags(unit_flags), .wb_valid(wb_valid),
      .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data), .wb_flags(wb_flags),
      .busy_units(busy_units), .err_spurious(err_spurious)
   );
   function automatic bit pend(logic [5:0] r);
      if (r == 6'd0) return 1'b0;
      for (int u = 0; u < N; u++) if (m_st[u] != 0 && m_rd[u] == r) return 1'b1;
      return 1'b0;
   endfunction
   function automatic logic [5:0] rnd_reg();
      logic [5:0] r;
      r = {1'($urandom), 5'($urandom_range(0, 2))};
      return r;
   endfunction
   task automatic drive(bit v, int u, logic [5:0] rd, logic [17:0] rs, logic [2:0] used);
      issue_valid = v;
      issue_unit = 2'(u);
      issue_rd = rd;
      issue_rs = rs;
      issue_rs_used = used;
   endtask
   task automatic settle();
      @(negedge clk);
      exp_ready = m_st[issue_unit] == 0 && !pend(issue_rd);
      for (int i = 0; i < 3; i++) if (issue_rs_used[i] && pend(issue_rs[6*i +: 6])) exp_ready = 1'b0;
      exp_start = (issue_valid && exp_ready) ? (4'b0001 << issue_unit) : 4'b0000;
      exp_sel = m_lock;
      for (int k = 0; k < N; k++) if (exp_sel < 0 && m_st[(m_rr + k) % N] == 2) exp_sel = (m_rr + k) % N;
      exp_wbv = exp_sel >= 0;
      for (int u = 0; u < N; u++) exp_busy[u] = m_st[u] != 0;
   endtask
   task automatic advance();
      bit acc, gnt;
      acc = issue_valid && exp_ready;
      gnt = exp_wbv && wb_ready;
      @(posedge clk);
      if (rst) begin
         for (int u = 0; u < N; u++) m_st[u] = 0;
         m_rr = 0;
         m_lock = -1;
         m_err = 1'b0;
      end else begin
         for (int u = 0; u < N; u++)
            if (unit_done[u]) begin
               if (m_st[u] == 1) begin
                  m_st[u] = 2;
                  m_data[u] = unit_result[u*XL +: XL];
                  m_flags[u] = unit_flags[u*NF +: NF];
               end else m_err = 1'b1;
            end
         if (gnt) begin
            m_st[exp_sel] = 0;
            m_rr = (exp_sel + 1) % N;
         end
         m_lock = (exp_wbv && !wb_ready) ? exp_sel : -1;
         if (acc) begin
            m_st[issue_unit] = 1;
            m_rd[issue_unit] = issue_rd;
         end
      end
      #1;
      for (int u = 0; u < N; u++) begin
         unit_result[u*XL +: XL] = $urandom;
         unit_flags[u*NF +: NF] = NF'($urandom);
      end
   endtask
   task automatic reset_dut();
      rst = 1'b1;
      drive(0, 0, 6'h00, 18'h0, 3'b000);
      unit_done = '0;
      wb_ready = 1'b0;
      settle(); advance();
      settle(); advance();
      rst = 1'b0;
   endtask
   task automatic drain();
      drive(0, 0, 6'h00, 18'h0, 3'b000);
      wb_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         for (int u = 0; u < N; u++) unit_done[u] = m_st[u] == 1;
         settle(); advance();
      end
      unit_done = '0;
   endtask
   task automatic test_reset();
      reset_dut();
      drive(0, 0, 6'h21, 18'h0, 3'b000);
      settle();
      checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
      checks++; if (busy_units !== 4'b0000) begin failures++; $display("FAIL reset_busy got=%b exp=0000", busy_units); end
      checks++; if (err_spurious !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_spurious); end
      checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", issue_ready); end
      checks++; if (unit_start !== 4'b0000) begin failures++; $display("FAIL reset_start got=%b exp=0000", unit_start); end
      advance();
   endtask
   task automatic test_raw();
      wb_ready = 1'b0;
      drive(1, 0, 6'h21, 18'h0, 3'b000);
      settle();
      checks++; if (unit_start !== 4'b0001) begin failures++; $display("FAIL raw_start got=%b exp=0001", unit_start); end
      advance();
      drive(1, 1, 6'h03, {6'h00, 6'h00, 6'h21}, 3'b001);
      for (int c = 0; c < 3; c++) begin
         settle();
         checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL raw_block got=%b exp=0", issue_ready); end
         advance();
      end
      unit_done = 4'b0001;
      wb_ready = 1'b1;
      settle(); advance();
      unit_done = '0;
      settle();
      checks++; if (wb_valid !== 1'b1 || wb_rd !== 6'h21) begin failures++; $display("FAIL raw_wb got=%b/%h exp=1/21", wb_valid, wb_rd); end
      checks++; if (wb_data !== m_data[0] || wb_flags !== m_flags[0]) begin failures++; $display("FAIL raw_data got=%h/%h exp=%h/%h", wb_data, wb_flags, m_data[0], m_flags[0]); end
      checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL raw_bubble got=%b exp=0", issue_ready); end
      advance();
      settle();
      checks++; if (issue_ready !== 1'b1 || unit_start !== 4'b0010) begin failures++; $display("FAIL raw_release got=%b/%b exp=1/0010", issue_ready, unit_start); end
      advance();
      drain();
   endtask
   task automatic test_ooo();
      logic [5:0] order [$];
      wb_ready = 1'b1;
      for (int c = 0; c < 16; c++) begin
         drive(c < 2, c == 0 ? 1 : 2, c == 0 ? 6'h05 : 6'h06, 18'h0, 3'b000);
         unit_done = '0;
         if (c == 3) unit_done[2] = 1'b1;
         if (c == 11) unit_done[1] = 1'b1;
         settle();
         checks++; if (wb_valid !== exp_wbv) begin failures++; $display("FAIL ooo_valid c=%0d got=%b exp=%b", c, wb_valid, exp_wbv); end
         if (wb_valid && wb_ready) order.push_back(wb_rd);
         advance();
      end
      unit_done = '0;
      checks++;
      if (order.size() != 2 || order[0] !== 6'h06 || order[1] !== 6'h05) begin
         failures++;
         $display("FAIL ooo_order got n=%0d first=%h exp 2 results 06 then 05", order.size(), order.size() > 0 ? order[0] : 6'h3f);
      end
      drain();
   endtask
   task automatic test_rr();
      logic [5:0] seq [3] = '{6'h12, 6'h13, 6'h11};
      int unit_of [3] = '{1, 2, 0};
      reset_dut();
      wb_ready = 1'b1;
      drive(1, 0, 6'h10, 18'h0, 3'b000);
      settle(); advance();
      drive(0, 0, 6'h00, 18'h0, 3'b000);
      unit_done = 4'b0001;
      settle(); advance();
      unit_done = '0;
      settle(); advance();
      wb_ready = 1'b0;
      for (int u = 0; u < 3; u++) begin
         drive(1, u, 6'(6'h11 + u), 18'h0, 3'b000);
         settle(); advance();
      end
      drive(0, 0, 6'h00, 18'h0, 3'b000);
      unit_done = 4'b0111;
      settle(); advance();
      unit_done = '0;
      wb_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         settle();
         checks++;
         if (wb_valid !== 1'b1 || wb_rd !== seq[k] || wb_data !== m_data[unit_of[k]]) begin
            failures++;
            $display("FAIL rr_grant k=%0d got=%b/%h/%h exp=1/%h/%h", k, wb_valid, wb_rd, wb_data, seq[k], m_data[unit_of[k]]);
         end
         advance();
      end
      settle();
      checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rr_empty got=%b exp=0", wb_valid); end
      advance();
   endtask
   task automatic test_stall();
      logic [XL-1:0] d;
      reset_dut();
      drive(1, 2, 6'h22, 18'h0, 3'b000);
      settle(); advance();
      drive(1, 0, 6'h20, 18'h0, 3'b000);
      settle(); advance();
      drive(0, 0, 6'h00, 18'h0, 3'b000);
      unit_done = 4'b0100;
      settle(); advance();
      unit_done = '0;
      settle();
      d = wb_data;
      checks++; if (wb_valid !== 1'b1 || wb_rd !== 6'h22) begin failures++; $display("FAIL stall_first got=%b/%h exp=1/22", wb_valid, wb_rd); end
      advance();
      unit_done = 4'b0001;
      for (int c = 0; c < 5; c++) begin
         settle();
         checks++;
         if (wb_valid !== 1'b1 || wb_rd !== 6'h22 || wb_data !== d) begin
            failures++;
            $display("FAIL stall_hold c=%0d got=%b/%h/%h exp=1/22/%h", c, wb_valid, wb_rd, wb_data, d);
         end
         advance();
         unit_done = '0;
      end
      wb_ready = 1'b1;
      settle();
      checks++; if (wb_rd !== 6'h22) begin failures++; $display("FAIL stall_release got=%h exp=22", wb_rd); end
      advance();
      settle();
      checks++; if (wb_valid !== 1'b1 || wb_rd !== 6'h20) begin failures++; $display("FAIL stall_next got=%b/%h exp=1/20", wb_valid, wb_rd); end
      advance();
   endtask
   task automatic test_x0();
      wb_ready = 1'b0;
      drive(1, 1, 6'h00, 18'h0, 3'b000);
      settle();
      checks++; if (unit_start !== 4'b0010) begin failures++; $display("FAIL x0_start got=%b exp=0010", unit_start); end
      advance();
      drive(1, 3, 6'h00, 18'h0, 3'b111);
      settle();
      checks++; if (issue_ready !== 1'b1 || unit_start !== 4'b1000) begin failures++; $display("FAIL x0_noblock got=%b/%b exp=1/1000", issue_ready, unit_start); end
      advance();
      drain();
   endtask
   task automatic test_midrun_reset();
      wb_ready = 1'b1;
      drive(1, 1, 6'h15, 18'h0, 3'b000);
      settle(); advance();
      drive(0, 0, 6'h00, 18'h0, 3'b000);
      settle(); advance();
      rst = 1'b1;
      settle(); advance();
      rst = 1'b0;
      unit_done = 4'b0010;
      settle();
      checks++; if (busy_units !== 4'b0000 || wb_valid !== 1'b0) begin failures++; $display("FAIL midrst_state got=%b/%b exp=0000/0", busy_units, wb_valid); end
      advance();
      unit_done = '0;
      drive(1, 1, 6'h15, {12'h000, 6'h15}, 3'b001);
      settle();
      checks++; if (err_spurious !== 1'b1) begin failures++; $display("FAIL midrst_err got=%b exp=1", err_spurious); end
      checks++; if (wb_valid !== 1'b0 || issue_ready !== 1'b1) begin failures++; $display("FAIL midrst_clean got=%b/%b exp=0/1", wb_valid, issue_ready); end
      advance();
      drain();
   endtask
   task automatic test_random();
      int cnt [N];
      int iu;
      bit acc;
      reset_dut();
      for (int u = 0; u < N; u++) cnt[u] = 0;
      for (int c = 0; c < 400; c++) begin
         for (int u = 0; u < N; u++) unit_done[u] = cnt[u] == 1;
         drive($urandom_range(0, 1) == 1, int'($urandom_range(0, N - 1)), rnd_reg(), {rnd_reg(), rnd_reg(), rnd_reg()}, 3'($urandom));
         wb_ready = $urandom_range(0, 3) != 0;
         settle();
         checks++; if (issue_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, issue_ready, exp_ready); end
         checks++; if (unit_start !== exp_start) begin failures++; $display("FAIL rnd_start c=%0d got=%b exp=%b", c, unit_start, exp_start); end
         checks++; if (wb_valid !== exp_wbv) begin failures++; $display("FAIL rnd_wb_valid c=%0d got=%b exp=%b", c, wb_valid, exp_wbv); end
         checks++; if (busy_units !== exp_busy) begin failures++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy_units, exp_busy); end
         checks++; if (err_spurious !== m_err) begin failures++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, err_spurious, m_err); end
         if (exp_wbv) begin
            checks++;
            if (wb_rd !== m_rd[exp_sel] || wb_data !== m_data[exp_sel] || wb_flags !== m_flags[exp_sel]) begin
               failures++;
               $display("FAIL rnd_wb c=%0d got=%h/%h/%h exp=%h/%h/%h", c, wb_rd, wb_data, wb_flags, m_rd[exp_sel], m_data[exp_sel], m_flags[exp_sel]);
            end
         end
         acc = issue_valid && exp_ready;
         iu = int'(issue_unit);
         advance();
         for (int u = 0; u < N; u++) if (cnt[u] > 0) cnt[u]--;
         if (acc) cnt[iu] = $urandom_range(1, 6);
      end
      unit_done = '0;
   endtask
   initial begin
      rst = 1'b1;
      unit_done = '0;
      unit_result = '0;
      unit_flags = '0;
      wb_ready = 1'b0;
      drive(0, 0, 6'h00, 18'h0, 3'b000);
      m_rr = 0;
      m_lock = -1;
      m_err = 1'b0;
      for (int u = 0; u < N; u++) m_st[u] = 0;
      test_reset();
      test_raw();
      test_ooo();
      test_rr();
      test_stall();
      test_x0();
      test_midrun_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
